// File: rtl/spi_slave_tx_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and defaults for the SPI slave MISO transmitter.
//   tx_state_t      : transmitter FSM state (IDLE / SHIFT / HOLD)
//   SPI_WIDTH       : default bits per frame
//   SPI_SYNC_STAGES : default synchronizer depth for sclk/cs
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_WIDTH       = 8;
   localparam int SPI_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/spi_slave_tx_if.sv
// -----------------------------------------------------------------------------
// spi_slave_tx_if
// Bundles the load handshake, the SPI pins and the status pulses of the
// slave transmitter.
//   slave  modport : transmitter side (spi_slave_tx)
//   master modport : host / SPI master side (driver of din, newd, sclk, cs)
// Signals:
//   din, newd, ready        : one-entry holding-buffer load handshake
//   sclk, cs                : SPI clock / chip select from the master
//   miso, miso_oe           : serial data and pad enable toward the master
//   done, underrun, aborted : one-clk status pulses
// -----------------------------------------------------------------------------
interface spi_slave_tx_if
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH
);

   logic [WIDTH-1:0] din;
   logic             newd;
   logic             ready;
   logic             sclk;
   logic             cs;
   logic             miso;
   logic             miso_oe;
   logic             done;
   logic             underrun;
   logic             aborted;

   modport slave (
      input  din, newd, sclk, cs,
      output ready, miso, miso_oe, done, underrun, aborted
   );

   modport master (
      output din, newd, sclk, cs,
      input  ready, miso, miso_oe, done, underrun, aborted
   );

endinterface

// File: rtl/spi_slave_tx_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings an asynchronous pin into the clk domain through SYNC_STAGES flops,
// then one edge-detect stage that registers the level together with the
// rise/fall pulses. Pulses therefore appear SYNC_STAGES+1 clk after the pin.
// Ports:
//   clk, rst  : system clock, async active-low reset
//   i_pin     : asynchronous input
//   o_level   : synchronized level (same timing as the pulses)
//   o_rise    : one-clk pulse on a 0->1 transition
//   o_fall    : one-clk pulse on a 1->0 transition
// Parameters:
//   SYNC_STAGES : synchronizer depth (2 or more)
//   RST_VAL     : idle level of the pin; loaded on reset so that releasing
//                 reset never produces a spurious edge
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_lvl;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync_out;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_lvl  <= RST_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         r_lvl  <= w_sync_out;
         r_rise <= w_sync_out & ~r_lvl;
         r_fall <= ~w_sync_out & r_lvl;
      end
   end

   assign o_level = r_lvl;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave_tx.sv
// -----------------------------------------------------------------------------
// spi_slave_tx
// SPI mode-0 slave MISO transmitter, LSB first, one byte per cs frame.
// sclk and cs are oversampled on clk. A one-entry holding buffer decouples
// the host load from the frame start.
// Ports:
//   clk  : system clock
//   rst  : async active-low reset
//   bus  : spi_slave_tx_if.slave (din/newd/ready, sclk/cs, miso/miso_oe,
//          done/underrun/aborted)
// Frame flow:
//   IDLE  --cs_fall-->  SHIFT (bit 0 driven, miso_oe high)
//   SHIFT --WIDTH sclk rises--> HOLD (done), --early cs_rise--> IDLE (aborted)
//   HOLD  --cs_rise--> IDLE
// -----------------------------------------------------------------------------
module spi_slave_tx
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic           clk,
   input  logic           rst,
   spi_slave_tx_if.slave  bus
);

   localparam int             CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

   // synchronized pin events
   logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
   logic w_cs_lvl,   w_cs_rise,   w_cs_fall;
   // the FSM is driven purely by the pulses; levels are kept for debug taps
   logic w_unused;

   tx_state_t        r_state, w_state_nxt;
   logic [WIDTH-1:0] r_buf,   w_buf;
   logic             r_buf_vld, w_buf_vld;
   logic [WIDTH-1:0] r_shift, w_shift;
   logic [CW-1:0]    r_cnt,   w_cnt;
   logic [CW-1:0]    w_cnt_inc;
   logic             r_miso,  w_miso;
   logic             r_oe,    w_oe;
   logic             r_done,  w_done;
   logic             r_und,   w_und;
   logic             r_abt,   w_abt;
   logic             w_accept;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst     (rst),
      .i_pin   (bus.sclk),
      .o_level (w_sclk_lvl),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk     (clk),
      .rst     (rst),
      .i_pin   (bus.cs),
      .o_level (w_cs_lvl),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   assign w_unused  = &{1'b0, w_sclk_lvl, w_cs_lvl};

   assign w_accept  = bus.newd & ~r_buf_vld;
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_buf     <= '0;
         r_buf_vld <= 1'b0;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_miso    <= 1'b0;
         r_oe      <= 1'b0;
         r_done    <= 1'b0;
         r_und     <= 1'b0;
         r_abt     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_buf     <= w_buf;
         r_buf_vld <= w_buf_vld;
         r_shift   <= w_shift;
         r_cnt     <= w_cnt;
         r_miso    <= w_miso;
         r_oe      <= w_oe;
         r_done    <= w_done;
         r_und     <= w_und;
         r_abt     <= w_abt;
      end
   end

   // --------------------------------------------------------------- next state
   // cs_rise is tested before any sclk edge so it wins a same-cycle collision.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_cs_fall) w_state_nxt = SHIFT;
         SHIFT: begin
            if (w_cs_rise)                                w_state_nxt = IDLE;
            else if (w_sclk_rise && w_cnt_inc == CNT_MAX) w_state_nxt = HOLD;
         end
         HOLD:    if (w_cs_rise) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------- outputs / data
   always_comb begin
      w_buf     = r_buf;
      w_buf_vld = r_buf_vld;
      w_shift   = r_shift;
      w_cnt     = r_cnt;
      w_miso    = r_miso;
      w_oe      = r_oe;
      w_done    = 1'b0;
      w_und     = 1'b0;
      w_abt     = 1'b0;

      if (w_accept) begin
         w_buf     = bus.din;
         w_buf_vld = 1'b1;
      end

      case (r_state)
         IDLE: begin
            if (w_cs_fall) begin
               w_cnt = '0;
               if (r_buf_vld) begin
                  w_shift   = r_buf;
                  w_buf_vld = 1'b0;
               end else if (w_accept) begin
                  // load arrives exactly at frame start: skip the buffer
                  w_shift   = bus.din;
                  w_buf     = r_buf;
                  w_buf_vld = 1'b0;
               end else begin
                  w_shift = '0;
                  w_und   = 1'b1;
               end
               w_miso = w_shift[0];
               w_oe   = 1'b1;
            end
         end

         SHIFT: begin
            if (w_cs_rise) begin
               // short frame: shifter contents are simply dropped
               w_abt  = 1'b1;
               w_miso = 1'b0;
               w_oe   = 1'b0;
               w_cnt  = '0;
            end else if (w_sclk_rise) begin
               w_cnt = w_cnt_inc;
               if (w_cnt_inc == CNT_MAX) begin
                  w_done = 1'b1;
                  w_miso = 1'b0;
               end
            end else if (w_sclk_fall) begin
               w_shift = {1'b0, r_shift[WIDTH-1:1]};
               w_miso  = w_shift[0];
            end
         end

         HOLD: begin
            if (w_cs_rise) begin
               w_miso = 1'b0;
               w_oe   = 1'b0;
               w_cnt  = '0;
            end
         end

         default: begin
            w_miso = 1'b0;
            w_oe   = 1'b0;
            w_cnt  = '0;
         end
      endcase
   end

   assign bus.ready    = ~r_buf_vld;
   assign bus.miso     = r_miso;
   assign bus.miso_oe  = r_oe;
   assign bus.done     = r_done;
   assign bus.underrun = r_und;
   assign bus.aborted  = r_abt;

endmodule
